// File: rtl/force_wb_receiver.sv
// force_wb_receiver: receiving end of the force write-back link.
// Accepts force packets over valid/ready, accumulates them into a per-cell
// force cache through a three-stage read-modify-write pipeline, provides a
// one-cycle-latency readout port and sweeps the cache to zero between timesteps.
// Optional feature macro: FORCE_SAT_EN (saturating adds plus sticky sat_flag).
module force_wb_receiver #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ID_WIDTH-1:0]     in_particle_id,
  input  logic [DATA_WIDTH-1:0]   in_force_x,
  input  logic [DATA_WIDTH-1:0]   in_force_y,
  input  logic [DATA_WIDTH-1:0]   in_force_z,
  input  logic                    clear,
  input  logic                    rd_en,
  input  logic [ID_WIDTH-1:0]     rd_addr,
  output logic                    rd_valid,
  output logic [3*DATA_WIDTH-1:0] rd_data,
  output logic [15:0]             accum_count,
  output logic                    clearing,
  output logic                    pipe_empty
`ifdef FORCE_SAT_EN
  ,
  output logic                    sat_flag
`endif
);

  localparam int DEPTH = 1 << ID_WIDTH;
  localparam int W     = 3 * DATA_WIDTH;

  typedef enum logic {CLEAR, ACCUM} state_t;

  logic [W-1:0] mem [DEPTH];

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                clear_pending_q, clear_pending_d;
  logic [15:0]         accum_count_q, accum_count_d;
  logic                s0_v_q, s0_v_d, s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [ID_WIDTH-1:0] s0_id_q, s0_id_d, s1_id_q, s1_id_d, s2_id_q, s2_id_d;
  logic [W-1:0]        s0_inc_q, s0_inc_d, s1_inc_q, s1_inc_d;
  logic [W-1:0]        s1_rdata_q, s1_rdata_d, s2_sum_q, s2_sum_d;
  logic                rd_valid_q, rd_valid_d;
  logic [W-1:0]        rd_data_q, rd_data_d;
  logic                accept, pipe_busy;
  logic [W-1:0]        s1_old, sum;
  logic                wr_en;
  logic [ID_WIDTH-1:0] wr_addr;
  logic [W-1:0]        wr_data;
`ifdef FORCE_SAT_EN
  logic                sat_q, sat_d, sat_hit;
`endif

  assign in_ready    = (state_q == ACCUM) && !clear_pending_q && !rd_en;
  assign accept      = in_valid && in_ready;
  assign pipe_busy   = s0_v_q || s1_v_q || s2_v_q;
  assign clearing    = (state_q == CLEAR);
  assign pipe_empty  = (state_q == ACCUM) && !pipe_busy && !clear_pending_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign accum_count = accum_count_q;
`ifdef FORCE_SAT_EN
  assign sat_flag    = sat_q;
`endif

  // S2 add: the packet just written is forwarded to a same-ID successor in S1,
  // whose RAM read was issued before that write landed.
  always_comb begin
    logic [DATA_WIDTH-1:0] a, b, r;
    s1_old = (s2_v_q && (s2_id_q == s1_id_q)) ? s2_sum_q : s1_rdata_q;
    sum    = '0;
`ifdef FORCE_SAT_EN
    sat_hit = 1'b0;
`endif
    for (int unsigned i = 0; i < 3; i++) begin
      a = s1_old[i*DATA_WIDTH +: DATA_WIDTH];
      b = s1_inc_q[i*DATA_WIDTH +: DATA_WIDTH];
      r = a + b;
`ifdef FORCE_SAT_EN
      if ((a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (r[DATA_WIDTH-1] != a[DATA_WIDTH-1])) begin
        sat_hit = 1'b1;
        r = a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
`endif
      sum[i*DATA_WIDTH +: DATA_WIDTH] = r;
    end
  end

  // Single cache write port: zero sweep in CLEAR, accumulation write-back in ACCUM.
  always_comb begin
    wr_en   = (state_q == CLEAR) || s1_v_q;
    wr_addr = (state_q == CLEAR) ? clr_addr_q : s1_id_q;
    wr_data = (state_q == CLEAR) ? '0 : sum;
  end

  // Next-state logic: pipeline advance, readout capture and CLEAR/ACCUM control.
  always_comb begin
    s0_v_d     = accept;
    s0_id_d    = in_particle_id;
    s0_inc_d   = {in_force_z, in_force_y, in_force_x};
    s1_v_d     = s0_v_q;
    s1_id_d    = s0_id_q;
    s1_inc_d   = s0_inc_q;
    s1_rdata_d = mem[s0_id_q];
    s2_v_d     = s1_v_q;
    s2_id_d    = s1_id_q;
    s2_sum_d   = sum;

    rd_valid_d = rd_en && (state_q == ACCUM);
    rd_data_d  = rd_valid_d ? mem[rd_addr] : rd_data_q;

    state_d         = state_q;
    clr_addr_d      = clr_addr_q;
    clear_pending_d = clear_pending_q;
    accum_count_d   = accum_count_q;
    if (s1_v_q && (accum_count_q != 16'hFFFF)) accum_count_d = accum_count_q + 16'd1;
`ifdef FORCE_SAT_EN
    sat_d = sat_q | (s1_v_q & sat_hit);
`endif

    case (state_q)
      CLEAR: begin
        if (clear) begin
          clr_addr_d = '0;
        end else if (clr_addr_q == {ID_WIDTH{1'b1}}) begin
          state_d       = ACCUM;
          clr_addr_d    = '0;
          accum_count_d = '0;
`ifdef FORCE_SAT_EN
          sat_d         = 1'b0;
`endif
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      ACCUM: begin
        // A clear arriving as the sweep is entered is covered by that sweep.
        if (clear_pending_q && !pipe_busy) begin
          state_d         = CLEAR;
          clear_pending_d = 1'b0;
          clr_addr_d      = '0;
        end else if (clear) begin
          clear_pending_d = 1'b1;
        end
      end
    endcase
  end

  // State registers; reset flushes the pipeline and restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= CLEAR;
      clr_addr_q      <= '0;
      clear_pending_q <= 1'b0;
      accum_count_q   <= '0;
      s0_v_q          <= 1'b0;
      s1_v_q          <= 1'b0;
      s2_v_q          <= 1'b0;
      s0_id_q         <= '0;
      s1_id_q         <= '0;
      s2_id_q         <= '0;
      s0_inc_q        <= '0;
      s1_inc_q        <= '0;
      s1_rdata_q      <= '0;
      s2_sum_q        <= '0;
      rd_valid_q      <= 1'b0;
      rd_data_q       <= '0;
`ifdef FORCE_SAT_EN
      sat_q           <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      clr_addr_q      <= clr_addr_d;
      clear_pending_q <= clear_pending_d;
      accum_count_q   <= accum_count_d;
      s0_v_q          <= s0_v_d;
      s1_v_q          <= s1_v_d;
      s2_v_q          <= s2_v_d;
      s0_id_q         <= s0_id_d;
      s1_id_q         <= s1_id_d;
      s2_id_q         <= s2_id_d;
      s0_inc_q        <= s0_inc_d;
      s1_inc_q        <= s1_inc_d;
      s1_rdata_q      <= s1_rdata_d;
      s2_sum_q        <= s2_sum_d;
      rd_valid_q      <= rd_valid_d;
      rd_data_q       <= rd_data_d;
`ifdef FORCE_SAT_EN
      sat_q           <= sat_d;
`endif
    end
  end

  // Cache write port; in-flight write-backs are dropped while rst is asserted.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_force_wb_receiver.sv
// Self-checking bench for force_wb_receiver (DATA_WIDTH=32, ID_WIDTH=7).
// Reference model: per-ID force arrays updated from a queue of accepted
// packets, each becoming visible to reads three cycles after acceptance.
module tb_force_wb_receiver;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, clear, rd_en, rd_valid, clearing, pipe_empty;
  logic [6:0]  in_particle_id, rd_addr;
  logic [31:0] in_force_x, in_force_y, in_force_z;
  logic [95:0] rd_data;
  logic [15:0] accum_count;
`ifdef FORCE_SAT_EN
  logic        sat_flag;
`endif

  always #5 clk = ~clk;

  force_wb_receiver #(.DATA_WIDTH(32), .ID_WIDTH(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_particle_id(in_particle_id), .in_force_x(in_force_x),
    .in_force_y(in_force_y), .in_force_z(in_force_z), .clear(clear),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .accum_count(accum_count), .clearing(clearing), .pipe_empty(pipe_empty)
`ifdef FORCE_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  typedef struct {
    int          c;
    logic [6:0]  id;
    logic [31:0] x, y, z;
  } pkt_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  pkt_t        q[$];
  logic [31:0] mx[128], my[128], mz[128];
  int          mcnt;
  int          last_acc;
  bit          prev_rd;
  logic [95:0] prev_exp;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] madd(input logic [31:0] a, input logic [31:0] b);
`ifdef FORCE_SAT_EN
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
`else
    return a + b;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) begin
      mx[i] = '0; my[i] = '0; mz[i] = '0;
    end
    mcnt = 0; q.delete(); last_acc = -100; prev_rd = 0;
  endtask

  task automatic apply(input pkt_t p);
    mx[p.id] = madd(mx[p.id], p.x);
    my[p.id] = madd(my[p.id], p.y);
    mz[p.id] = madd(mz[p.id], p.z);
    if (mcnt < 65535) mcnt++;
  endtask

  task automatic commit();
    while (q.size() > 0 && q[0].c <= cyc - 3) apply(q.pop_front());
  endtask

  task automatic commit_all();
    while (q.size() > 0) apply(q.pop_front());
  endtask

  task automatic idle();
    in_valid = 0; rd_en = 0; clear = 0;
    @(posedge clk); #1; cyc++;
    prev_rd = 0;
  endtask

  // Counts sampled cycles with clearing high; call before the first sweep edge.
  task automatic wait_sweep(input string tag);
    int n = 0;
    while (clearing === 1'b1 && n < 400) begin
      n++;
      idle();
    end
    chk(tag, n, 128);
  endtask

  task automatic step(input bit v, input logic [6:0] id, input logic [31:0] fx,
                      input logic [31:0] fy, input logic [31:0] fz,
                      input bit rd, input logic [6:0] ra, input bit clr);
    pkt_t p;
    commit();
    chk("accum_count", accum_count, mcnt);
    chk("pipe_empty", pipe_empty, (last_acc < cyc - 3));
    if (prev_rd) begin
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, prev_exp);
    end else begin
      chk("rd_valid_idle", rd_valid, 0);
    end
    in_valid = v; in_particle_id = id; in_force_x = fx; in_force_y = fy; in_force_z = fz;
    rd_en = rd; rd_addr = ra; clear = clr;
    #1;
    chk("in_ready", in_ready, !rd);
    prev_rd = rd;
    if (rd) prev_exp = {mz[ra], my[ra], mx[ra]};
    if (v && !rd) begin
      p.c = cyc; p.id = id; p.x = fx; p.y = fy; p.z = fz;
      q.push_back(p);
      last_acc = cyc;
    end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic send(input logic [6:0] id, input logic [31:0] fx, input logic [31:0] fy,
                      input logic [31:0] fz);
    step(1, id, fx, fy, fz, 0, '0, 0);
  endtask

  task automatic rd(input logic [6:0] a);
    step(0, '0, '0, '0, '0, 1, a, 0);
  endtask

  task automatic nop();
    step(0, '0, '0, '0, '0, 0, '0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [15:0] last_cnt;
    logic [31:0] rx, ry, rz;
    bit          v, r;

    rst = 1; in_valid = 0; rd_en = 0; clear = 0; in_particle_id = '0; rd_addr = '0;
    in_force_x = '0; in_force_y = '0; in_force_z = '0;
    model_reset();
    @(posedge clk); #1; cyc++;
    @(posedge clk); #1; cyc++;

    // Reset state and first sweep
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_accum_count", accum_count, 0);
    chk("rst_clearing", clearing, 1);
    chk("rst_pipe_empty", pipe_empty, 0);
`ifdef FORCE_SAT_EN
    chk("rst_sat_flag", sat_flag, 0);
`endif
    rst = 0;
    wait_sweep("sweep_after_reset");
    chk("clearing_done", clearing, 0);
    rd(0); rd(64); rd(127); nop();
    chk("t1_in_ready", in_ready, 1);

    // Back-to-back same-ID accumulation
    send(5, 32'd10, 0, 0);
    send(5, 32'hFFFF_FFFD, 0, 0);
    send(5, 32'd1, 0, 0);
    nop(); nop(); nop();
    rd(5); nop();
    chk("t2_id5", rd_data, 96'd8);
    chk("t2_count", accum_count, 3);

    // Interleaved IDs with a read stealing one cycle
    send(1, 0, 32'd100, 0);
    send(2, 0, 32'd100, 0);
    step(1, 1, 0, 32'd100, 0, 1, 7'd5, 0);
    send(1, 0, 32'd100, 0);
    send(2, 0, 32'd100, 0);
    nop(); nop(); nop();
    rd(1);
    chk("t3_id1", rd_data, {32'd0, 32'd200, 32'd0});
    rd(2); nop();
    chk("t3_id2_y", rd_data[63:32], 32'd200);
    chk("t3_count", accum_count, 7);

    // Overflow of one component
    send(9, 32'h7FFF_FFFF, 0, 0);
    send(9, 32'd1, 0, 0);
    nop(); nop(); nop();
    rd(9); nop();
`ifdef FORCE_SAT_EN
    chk("t5_x_sat", rd_data[31:0], 32'h7FFF_FFFF);
    chk("t5_sat_flag", sat_flag, 1);
`else
    chk("t5_x_wrap", rd_data[31:0], 32'h8000_0000);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      v  = ($urandom_range(0, 9) < 7);
      r  = ($urandom_range(0, 4) == 0);
      rx = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
      ry = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
      rz = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
      step(v, 7'(16 + $urandom_range(0, 7)), rx, ry, rz, r,
           $urandom_range(0, 1) ? 7'(16 + $urandom_range(0, 7)) : 7'($urandom_range(0, 127)), 0);
    end
    nop(); nop(); nop(); nop();
    for (int a = 16; a < 24; a++) rd(7'(a));
    nop();

    // Clear with two packets in flight
    send(3, 32'd1, 32'd2, 32'd3);
    step(1, 4, 32'd4, 32'd5, 32'd6, 0, '0, 1);
    in_valid = 0; rd_en = 0; clear = 0;
    #1;
    chk("t4_ready_pending", in_ready, 0);
    n = 0; last_cnt = accum_count;
    while (clearing !== 1'b1 && n < 50) begin
      last_cnt = accum_count;
      idle();
      n++;
    end
    commit_all();
    chk("t4_sweep_started", clearing, 1);
    chk("t4_count_before_sweep", last_cnt, mcnt);
    wait_sweep("sweep_after_clear");
    model_reset();
    chk("t4_count_zero", accum_count, 0);
    chk("t4_in_ready", in_ready, 1);
    chk("t4_pipe_empty", pipe_empty, 1);
`ifdef FORCE_SAT_EN
    chk("t4_sat_cleared", sat_flag, 0);
`endif
    rd(3); rd(4); rd(5); rd(0); rd(127); nop();

    // Reset with S1 and S2 occupied
    send(9, 32'd5, 0, 0);
    send(9, 32'd6, 0, 0);
    send(9, 32'd7, 0, 0);
    rst = 1;
    idle();
    chk("t6_clearing", clearing, 1);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_pipe_empty", pipe_empty, 0);
    chk("t6_count", accum_count, 0);
    chk("t6_rd_valid", rd_valid, 0);
    rst = 0;
    model_reset();
    wait_sweep("sweep_after_mid_reset");
    rd(9); nop();
    chk("t6_id9", rd_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
